soc_system_pesos_reader: RTL

//  Avalon-MM read master that fetches a block of 32-bit neuron weights from the pesos on-chip RAM slave.

---
 rtl/soc_system_pesos_reader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/soc_system_pesos_reader.sv
// rtl/soc_system_pesos_reader.sv - Avalon-MM burst-less read master streaming pesos RAM weights
module soc_system_pesos_reader #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0] JOB_ONE = (ADDR_W+1)'(1);
  localparam logic [CNT_W:0]  DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   remaining_nxt;
  logic [ADDR_W:0]   job_count;
  logic [ADDR_W:0]   popped;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflight_nxt;
  logic [CNT_W-1:0]  used;
  logic [CNT_W-1:0]  used_nxt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic active;
  logic credit_ok;

  assign active = (state == S_RUN) || (state == S_DRAIN);
  assign accept = avm_read && !avm_waitrequest;
  // Data only counts when a read is actually outstanding; anything else is stale.
  assign push   = avm_readdatavalid && active && (inflight != '0);
  assign pop    = st_valid && st_ready;

  assign remaining_nxt = accept ? (remaining - JOB_ONE) : remaining;
  assign inflight_nxt  = inflight + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, push};
  assign used_nxt      = used + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  // Reads in flight plus buffered words may never exceed the FIFO, so data is never dropped.
  assign credit_ok     = ({1'b0, inflight_nxt} + {1'b0, used_nxt}) < DEPTH_V;

  assign busy           = active;
  assign done           = (state == S_DONE);
  assign avm_chipselect = avm_read;
  assign avm_byteenable = 4'hF;
  assign st_valid       = (used != '0);
  assign st_data        = st_valid ? mem[rd_ptr] : '0;
  assign st_last        = st_valid && (popped == (job_count - JOB_ONE));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Job sequencing: issue until every read is accepted, then drain until the last word leaves.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept && (remaining_nxt == '0)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && st_last) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered Avalon request: load on start, advance on accept, hold while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_read    <= 1'b0;
      avm_address <= '0;
      remaining   <= '0;
      job_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          avm_read <= 1'b0;
          if (start) begin
            job_count   <= count;
            remaining   <= count;
            avm_address <= base_addr;
            avm_read    <= (count != '0);
          end
        end
        S_RUN: begin
          remaining <= remaining_nxt;
          if (accept) begin
            avm_address <= avm_address + ADDR_W'(1);
          end
          if (!(avm_read && avm_waitrequest)) begin
            avm_read <= (remaining_nxt != '0) && credit_ok;
          end
        end
        default: avm_read <= 1'b0;
      endcase
    end
  end

  // Credit and FIFO bookkeeping, cleared whenever no job is running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
      used     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      popped   <= '0;
    end else if (state == S_IDLE) begin
      inflight <= '0;
      used     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      popped   <= '0;
    end else begin
      inflight <= inflight_nxt;
      used     <= used_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        popped <= popped + JOB_ONE;
      end
    end
  end

  // FIFO storage; contents are only observable through st_data while st_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= avm_readdata;
    end
  end

endmodule
